seg_serial_tx: RTL and testbench

Serial transmitter for the seven-segment display path. It captures a 64-bit segment-pattern word: eight 8-bit per-digit patterns from the segment mapper, concatenated digit 7 first. It then shifts the word MSB-first into the board's external shift-register chain, generating the serial clock and data plus the clear and display-enable strobes. It sits between the display-data assembly logic and the board pins and is the driving end of the segment-pattern interface.

---
 rtl/seg_serial_tx.sv | 106 ++++++++++
 tb/tb_seg_serial_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_tx.sv
// Serial transmitter for the seven-segment chain: captures a pattern word and
// shifts it MSB-first with a generated serial clock, clear and display enable.
module seg_serial_tx #(
  parameter int DATA_WIDTH  = 64,
  parameter int HALF_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] par_data,
  output logic                  busy,
  output logic                  done,
  output logic                  s_clk,
  output logic                  s_data,
  output logic                  s_clrn,
  output logic                  s_pen
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int HW = $clog2(HALF_PERIOD) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [HW-1:0] LAST_HP  = HW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         bit_cnt;
  logic [HW-1:0]         hp_cnt;
  logic                  phase_end;
  logic                  bit_end;
  logic                  last_bit;

  // A bit ends at the last cycle of its high phase; s_clk is the phase flag.
  assign phase_end = (hp_cnt == LAST_HP);
  assign bit_end   = phase_end && s_clk;
  assign last_bit  = bit_end && (bit_cnt == LAST_BIT);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last_bit) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath and all outputs are registered so nothing combinational reaches the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      hp_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s_clk     <= 1'b0;
      s_data    <= 1'b0;
      s_clrn    <= 1'b0;
      s_pen     <= 1'b0;
    end else begin
      s_clrn <= 1'b1;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= par_data;
            bit_cnt   <= '0;
            hp_cnt    <= '0;
            s_clk     <= 1'b0;
            s_data    <= par_data[DATA_WIDTH-1];
            busy      <= 1'b1;
            s_pen     <= 1'b0;
          end
        end
        SHIFT: begin
          if (!phase_end) begin
            hp_cnt <= hp_cnt + 1'b1;
          end else begin
            hp_cnt <= '0;
            s_clk  <= ~s_clk;
            if (bit_end) begin
              shift_reg <= shift_reg << 1;
              s_data    <= shift_reg[DATA_WIDTH-2];
              if (last_bit) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                s_pen  <= 1'b1;
                s_data <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_tx.sv
// Bench for seg_serial_tx: default-rate and fast (HALF_PERIOD=1) instances
// checked against a cycle-indexed waveform model of the serial transfer.
module tb_seg_serial_tx;
  localparam int W  = 64;
  localparam int H  = 2;
  localparam int HF = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, start_f = 1'b0;
  logic [W-1:0] par_data = '0, par_data_f = '0;
  logic busy, done, s_clk, s_data, s_clrn, s_pen;
  logic busy_f, done_f, s_clk_f, s_data_f, s_clrn_f, s_pen_f;

  int errors = 0;
  int checks = 0;

  seg_serial_tx #(.DATA_WIDTH(W), .HALF_PERIOD(H)) dut (
    .clk(clk), .rst(rst), .start(start), .par_data(par_data),
    .busy(busy), .done(done), .s_clk(s_clk), .s_data(s_data),
    .s_clrn(s_clrn), .s_pen(s_pen)
  );

  seg_serial_tx #(.DATA_WIDTH(W), .HALF_PERIOD(HF)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .par_data(par_data_f),
    .busy(busy_f), .done(done_f), .s_clk(s_clk_f), .s_data(s_data_f),
    .s_clrn(s_clrn_f), .s_pen(s_pen_f)
  );

  always #5 clk = ~clk;

  // Runs one transfer on the default instance for 300 cycles, injecting ignored
  // starts and an optional mid-transfer reset, and summarises what was observed.
  task automatic xfer(input logic [W-1:0] word, input int ign_a, input int ign_b,
                      input int rst_cyc, output logic [W-1:0] got, output int rises,
                      output int done_cyc, output int done_cnt, output int busy_cnt,
                      output int wave_err, output int stab_err, output int rst_bad);
    logic prev_clk, prev_data, in_xfer, exp_clk, exp_data;
    got = '0; rises = 0; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    wave_err = 0; stab_err = 0; rst_bad = 0; prev_clk = 1'b0; prev_data = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; par_data = word;
    @(posedge clk); #1;
    start = 1'b0; par_data = {$urandom, $urandom};
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (rst_cyc > 0 && cyc == rst_cyc) begin
        rst = 1'b1;
        #1;
        if (busy !== 1'b0 || done !== 1'b0 || s_clk !== 1'b0 || s_data !== 1'b0 ||
            s_clrn !== 1'b0 || s_pen !== 1'b0) rst_bad++;
      end
      if (rst_cyc > 0 && cyc == rst_cyc + 3) rst = 1'b0;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (s_clk && !prev_clk) begin
        rises++;
        got = {got[W-2:0], s_data};
        if (s_data !== prev_data) stab_err++;
      end
      if (rst_cyc < 0) begin
        in_xfer  = (cyc <= 2 * H * W);
        exp_clk  = in_xfer && (((cyc - 1) % (2 * H)) >= H);
        exp_data = in_xfer ? word[W - 1 - (cyc - 1) / (2 * H)] : 1'b0;
        if (s_clk !== exp_clk || busy !== in_xfer || done !== (cyc == 2 * H * W + 1) ||
            (in_xfer && (s_data !== exp_data || s_pen !== 1'b0))) wave_err++;
      end
      prev_clk = s_clk; prev_data = s_data;
      @(posedge clk); #1;
      start    = (cyc + 1 == ign_a || cyc + 1 == ign_b);
      par_data = {$urandom, $urandom};
    end
    start = 1'b0;
  endtask

  task automatic fast_xfer(input logic [W-1:0] word, output logic [W-1:0] got,
                           output int rises, output int done_cyc, output int wave_err);
    logic prev_clk, exp_clk;
    got = '0; rises = 0; done_cyc = -1; wave_err = 0; prev_clk = 1'b0;
    @(posedge clk); #1;
    start_f = 1'b1; par_data_f = word;
    @(posedge clk); #1;
    start_f = 1'b0; par_data_f = ~word;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk);
      if (done_f && done_cyc < 0) done_cyc = cyc;
      if (s_clk_f && !prev_clk) begin
        rises++;
        got = {got[W-2:0], s_data_f};
      end
      exp_clk = (cyc <= 2 * HF * W) && (((cyc - 1) % (2 * HF)) >= HF);
      if (s_clk_f !== exp_clk || busy_f !== (cyc <= 2 * HF * W)) wave_err++;
      prev_clk = s_clk_f;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, s_clk, s_data, s_clrn, s_pen} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {busy, done, s_clk, s_data, s_clrn, s_pen});
    end
    checks++;
    if ({busy_f, done_f, s_clk_f, s_data_f, s_clrn_f, s_pen_f} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs_fast: got %b expected 000000",
               {busy_f, done_f, s_clk_f, s_data_f, s_clrn_f, s_pen_f});
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_clrn !== 1'b0) begin
      errors++;
      $display("FAIL clrn_before_edge: got %b expected 0", s_clrn);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, s_clk, s_data, s_clrn, s_pen} !== 6'b000010) begin
      errors++;
      $display("FAIL after_release: got %b expected 000010", {busy, done, s_clk, s_data, s_clrn, s_pen});
    end
  endtask

  task automatic check_full(input string name, input logic [W-1:0] word, input int ign_a, input int ign_b);
    logic [W-1:0] got;
    int rises, done_cyc, done_cnt, busy_cnt, wave_err, stab_err, rst_bad;
    xfer(word, ign_a, ign_b, -1, got, rises, done_cyc, done_cnt, busy_cnt, wave_err, stab_err, rst_bad);
    checks++;
    if (got !== word) begin errors++; $display("FAIL %s_word: got %h expected %h", name, got, word); end
    checks++;
    if (rises != W) begin errors++; $display("FAIL %s_rises: got %0d expected %0d", name, rises, W); end
    checks++;
    if (done_cyc != 2 * H * W + 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done: got cycle %0d count %0d expected cycle %0d count 1", name, done_cyc, done_cnt, 2 * H * W + 1);
    end
    checks++;
    if (busy_cnt != 2 * H * W) begin errors++; $display("FAIL %s_busy: got %0d expected %0d", name, busy_cnt, 2 * H * W); end
    checks++;
    if (wave_err != 0 || stab_err != 0) begin
      errors++;
      $display("FAIL %s_waveform: got %0d wave and %0d stability errors expected 0", name, wave_err, stab_err);
    end
    checks++;
    if (s_pen !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: got pen %b busy %b expected pen 1 busy 0", name, s_pen, busy);
    end
  endtask

  task automatic test_basic;
    check_full("basic", 64'h8000_0000_0000_0001, -1, -1);
  endtask

  task automatic test_pattern;
    check_full("pattern", 64'hDEAD_BEEF_0123_4567, -1, -1);
  endtask

  task automatic test_ignored_start;
    check_full("ignored_start", {$urandom, $urandom}, 10, 2 * H * W + 1);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] got;
    int rises, done_cyc, done_cnt, busy_cnt, wave_err, stab_err, rst_bad;
    xfer({$urandom, $urandom}, -1, -1, 100, got, rises, done_cyc, done_cnt, busy_cnt, wave_err, stab_err, rst_bad);
    checks++;
    if (rst_bad != 0) begin errors++; $display("FAIL reset_mid_async: got %0d bad samples expected 0", rst_bad); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL reset_mid_done: got %0d pulses expected 0", done_cnt); end
    checks++;
    if (s_pen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got pen %b busy %b expected pen 0 busy 0", s_pen, busy);
    end
    check_full("after_reset", {$urandom, $urandom}, -1, -1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 2; n++) check_full("random", {$urandom, $urandom}, $urandom_range(2, 250), -1);
  endtask

  task automatic test_fast;
    logic [W-1:0] word, got;
    int rises, done_cyc, wave_err;
    for (int n = 0; n < 2; n++) begin
      word = (n == 0) ? {W{1'b1}} : {$urandom, $urandom};
      fast_xfer(word, got, rises, done_cyc, wave_err);
      checks++;
      if (got !== word || rises != W) begin
        errors++;
        $display("FAIL fast_word: got %h with %0d rises expected %h with %0d", got, rises, word, W);
      end
      checks++;
      if (done_cyc != 2 * HF * W + 1) begin
        errors++;
        $display("FAIL fast_done: got %0d expected %0d", done_cyc, 2 * HF * W + 1);
      end
      checks++;
      if (wave_err != 0 || s_pen_f !== 1'b1) begin
        errors++;
        $display("FAIL fast_waveform: got %0d errors pen %b expected 0 errors pen 1", wave_err, s_pen_f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
